music_player: RTL and testbench
===============================

# music_player

Parametrised melody/alert generator for the bottle-filling controller. It replaces the fixed single-tone buzzer with a pattern player. On a start request it steps through a selectable table of notes, each with its own pitch divider and duration, and drives a square wave on `Music`. It runs on one clock, with internal prescaling for note timing, and sits beside the fill-state logic, which requests patterns (e.g. "all full", "fault").

## Interface
- `CLK_HZ`, 100000: system clock frequency. Documentation only; dividers are precomputed in the package.
- `DIV_W`, 10: width of the pitch half-period divider.
- `DUR_W`, 10: width of the note duration, in ticks.
- `NOTES`, 8: entries per pattern.
- `PATTERNS`, 4: number of selectable patterns.
- `TICK_CYC`, 100: clock cycles per duration tick (1 ms at 100 kHz).
- `GAP_TICKS`, 10: silent gap after each note, in ticks.
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  play request, sampled every cycle.
- `sel`  in  clog2(PATTERNS)  pattern index, captured with `start`.
- `stop`  in  1  abort request.
- `busy`  out  1  high while a pattern is playing.
- `done`  out  1  one-cycle pulse on normal completion.
- `note_idx`  out  clog2(NOTES)  index of the current entry.
- `Music`  out  1  square-wave audio output.

## Operation
- Each table entry is {div, dur}.
  - div = 0 means a rest: `Music` is held 0.
  - dur = 0 is a terminator and ends the pattern.
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - `start`=1 and `stop`=0 → capture `sel`, set idx=0, go to LOAD.
- LOAD:
  - Read entry[sel][idx], clear the tick prescaler, the duration counter and the pitch counter.
  - If dur = 0 → end.
  - Otherwise → PLAY.
- PLAY:
  - The pitch counter counts 0..div-1. On reaching div-1 it wraps and `Music` toggles, so f = CLK_HZ/(2·div).
  - The duration counter advances once per tick. When it reaches dur → `Music` is forced 0 and the FSM goes to GAP.
- GAP:
  - After GAP_TICKS ticks: if idx = NOTES-1 → end; otherwise idx+1 → LOAD.
- End (no repeat): pulse `done` for one cycle, go to IDLE.
- `stop`=1 in any non-IDLE state → IDLE on the next edge, `Music` forced 0, no `done`.
- `start` while `busy` is ignored, and `sel` changes while busy are ignored.
- `start` and `stop` in the same cycle: `stop` wins.

## Timing
- Reset values: `Music`=0, `busy`=0, `done`=0, `note_idx`=0, state IDLE, all counters 0.
- `start` sampled at edge 0 → LOAD at edge 1 (`busy`=1) → PLAY at edge 2.
- First `Music` rise occurs div cycles after entering PLAY.
- A note occupies exactly dur·TICK_CYC cycles in PLAY. The gap occupies exactly GAP_TICKS·TICK_CYC cycles. LOAD adds 1 cycle per note.
- `done` is asserted in the cycle after the last GAP or terminating LOAD. `busy` falls in the same cycle.
- Counters never wrap in normal use:
  - The duration counter is DUR_W bits wide.
  - The pitch counter is DIV_W bits wide.
  - The tick prescaler is clog2(TICK_CYC) bits wide.
- Reset asserted mid-note returns to the reset values immediately, with no `done`.

## Configuration
- `MUSIC_REPEAT_EN` defined: at the end of a pattern the FSM goes to LOAD with idx=0 instead of ending. It loops until `stop`, and `done` never pulses.
  - A pattern whose entry 0 is a terminator still ends with `done`, to avoid a zero-length loop.
- Undefined: one-shot behaviour as described in Operation.

## Structure
- Package `music_pkg` holds:
  - the note entry typedef {div, dur};
  - named pitch constants, e.g. `DIV_A5` = 57 at 100 kHz;
  - the pattern table constant, PATTERNS × NOTES entries;
  - the FSM state enum.
- Sub-module `tone_gen`: pitch counter plus output toggle.
  - Inputs: `en`, `div`, `clr`.
  - Output: `wave`.
  - `wave` is forced 0 when `en`=0 or div=0.
- The top level holds the FSM, tick prescaler, duration counter and index.

## Test plan
All scenarios use TICK_CYC=4 and GAP_TICKS=1.
- Reset mid-PLAY: assert `RST_N`=0 → `Music`, `busy`, `done` and `note_idx` are 0 asynchronously and stay 0 after release.
- Pattern {div=5,dur=3},{div=0,dur=2},terminator:
  - `Music` toggles every 5 cycles for 12 cycles.
  - Then 4 gap cycles, then 8 rest cycles at 0, then 4 gap cycles.
  - `done` is one cycle; `busy` totals 31 cycles.
- Full 8-entry pattern with no terminator → `note_idx` steps 0..7, then `done`. A second `start` during play has no effect.
- `stop` at note 2 → `Music`=0 and `busy`=0 on the next edge, no `done`. `start` and `stop` asserted together in IDLE → stays IDLE.
- Terminator at entry 0 → `done` 2 cycles after `start`, `Music` never toggles. This holds both with and without `MUSIC_REPEAT_EN`.
- `MUSIC_REPEAT_EN` build → `note_idx` wraps 7→0 with no `done`, continuous for 3 loops, and `stop` ends it.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types for the melody/alert player: note entry, 100 kHz pitch dividers,
// the default pattern table and the player FSM states.
package music_pkg;

  localparam int ENTRY_DIV_W    = 10;
  localparam int ENTRY_DUR_W    = 10;
  localparam int TABLE_NOTES    = 8;
  localparam int TABLE_PATTERNS = 4;

  typedef struct packed {
    logic [ENTRY_DIV_W-1:0] div;
    logic [ENTRY_DUR_W-1:0] dur;
  } note_t;

  typedef note_t    [TABLE_NOTES-1:0]    pattern_t;
  typedef pattern_t [TABLE_PATTERNS-1:0] table_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Half-period dividers for a 100 kHz clock: div = round(100000 / (2 * f)).
  localparam int DIV_REST = 0;
  localparam int DIV_A4   = 114;
  localparam int DIV_C5   = 96;
  localparam int DIV_E5   = 76;
  localparam int DIV_G5   = 64;
  localparam int DIV_A5   = 57;
  localparam int DIV_C6   = 48;

  function automatic note_t mk_note(input int div, input int dur);
    note_t n;
    n.div = ENTRY_DIV_W'(div);
    n.dur = ENTRY_DUR_W'(dur);
    return n;
  endfunction

  // Unwritten entries stay zero, i.e. terminators. Durations are in 1 ms ticks.
  function automatic table_t build_table();
    table_t t;
    t = '0;
    // 0: "all full" rising arpeggio
    t[0][0] = mk_note(DIV_C5, 120);
    t[0][1] = mk_note(DIV_E5, 120);
    t[0][2] = mk_note(DIV_G5, 120);
    t[0][3] = mk_note(DIV_C6, 300);
    // 1: "fault" triple beep with a low tail
    t[1][0] = mk_note(DIV_A5, 200);
    t[1][1] = mk_note(DIV_REST, 100);
    t[1][2] = mk_note(DIV_A5, 200);
    t[1][3] = mk_note(DIV_REST, 100);
    t[1][4] = mk_note(DIV_A5, 200);
    t[1][5] = mk_note(DIV_A4, 400);
    // 2: short acknowledge beep
    t[2][0] = mk_note(DIV_G5, 80);
    // 3: eight-note warning, no terminator
    t[3][0] = mk_note(DIV_E5, 150);
    t[3][1] = mk_note(DIV_C5, 150);
    t[3][2] = mk_note(DIV_E5, 150);
    t[3][3] = mk_note(DIV_C5, 150);
    t[3][4] = mk_note(DIV_A4, 150);
    t[3][5] = mk_note(DIV_A4, 150);
    t[3][6] = mk_note(DIV_A4, 150);
    t[3][7] = mk_note(DIV_A4, 300);
    return t;
  endfunction

  localparam table_t PATTERN_TABLE = build_table();

endpackage

// File: rtl/tone_gen.sv
// Square-wave pitch generator: toggles its output every div enabled cycles.
// The output is forced low when disabled or when div is zero (a rest).
module tone_gen
  import music_pkg::*;
#(
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             wave
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wave_q, wave_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (clr) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (en && (div != '0)) begin
      if (cnt_q == div - DIV_W'(1)) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  assign wave = wave_q & en & (div != '0);

endmodule

// File: rtl/music_player.sv
// Pattern player: steps through a table of {div, dur} notes with a silent gap after each.
// Define MUSIC_REPEAT_EN to loop the pattern until stop instead of ending with done.
module music_player
  import music_pkg::*;
#(
  parameter int     CLK_HZ    = 100000,
  parameter int     DIV_W     = 10,
  parameter int     DUR_W     = 10,
  parameter int     NOTES     = 8,
  parameter int     PATTERNS  = 4,
  parameter int     TICK_CYC  = 100,
  parameter int     GAP_TICKS = 10,
  parameter table_t TABLE     = PATTERN_TABLE,
  localparam int    SEL_W     = (PATTERNS > 1) ? $clog2(PATTERNS) : 1,
  localparam int    IDX_W     = (NOTES > 1) ? $clog2(NOTES) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx,
  output logic             Music
);

  localparam int               PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES - 1);

  // The table's dividers are only meaningful at the clock rate they were computed for.
  if (CLK_HZ <= 0) begin : g_clk_hz_unset
  end

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] dcnt_q, dcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             done_q, done_d;

  note_t            entry;
  logic [DUR_W-1:0] entry_dur;
  logic             tick, note_over, gap_over, last_idx;
  logic             pattern_end, advance, restart;
  logic             tone_en, tone_clr, wave;

  assign entry     = TABLE[sel_q][idx_q];
  assign entry_dur = DUR_W'(entry.dur);
  assign tick      = (pre_q == PRE_LAST);
  assign note_over = (state_q == ST_PLAY) && tick && (dcnt_q == dur_q - DUR_W'(1));
  assign gap_over  = (state_q == ST_GAP) && tick && (dcnt_q == GAP_LAST);
  assign last_idx  = (idx_q == IDX_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pattern_end = 1'b0;
    advance     = 1'b0;
    restart     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (entry_dur == '0) begin
`ifdef MUSIC_REPEAT_EN
          // A terminator at entry 0 would loop on LOAD forever, so it still ends.
          if (idx_q == '0) begin
            state_d     = ST_IDLE;
            pattern_end = 1'b1;
          end else begin
            state_d = ST_LOAD;
            restart = 1'b1;
          end
`else
          state_d     = ST_IDLE;
          pattern_end = 1'b1;
`endif
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop) state_d = ST_IDLE;
        else if (note_over) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (gap_over) begin
          if (last_idx) begin
`ifdef MUSIC_REPEAT_EN
            state_d = ST_LOAD;
            restart = 1'b1;
`else
            state_d     = ST_IDLE;
            pattern_end = 1'b1;
`endif
          end else begin
            state_d = ST_LOAD;
            advance = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q  <= '0;
      idx_q  <= '0;
      pre_q  <= '0;
      dcnt_q <= '0;
      div_q  <= '0;
      dur_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      dcnt_q <= dcnt_d;
      div_q  <= div_d;
      dur_q  <= dur_d;
      done_q <= done_d;
    end
  end

  // The duration counter times the note in PLAY and is reused for the gap in GAP.
  always_comb begin
    sel_d  = sel_q;
    idx_d  = idx_q;
    pre_d  = pre_q;
    dcnt_d = dcnt_q;
    div_d  = div_q;
    dur_d  = dur_q;
    done_d = pattern_end;
    unique case (state_q)
      ST_IDLE: begin
        if (state_d == ST_LOAD) sel_d = sel;
      end
      ST_LOAD: begin
        pre_d  = '0;
        dcnt_d = '0;
        div_d  = DIV_W'(entry.div);
        dur_d  = entry_dur;
      end
      ST_PLAY, ST_GAP: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick) dcnt_d = note_over ? '0 : dcnt_q + DUR_W'(1);
      end
    endcase
    if (advance) idx_d = idx_q + IDX_W'(1);
    if (restart || (state_d == ST_IDLE)) idx_d = '0;
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    tone_en  = (state_q == ST_PLAY);
    tone_clr = (state_q == ST_LOAD);
    done     = done_q;
    note_idx = idx_q;
    Music    = wave;
  end

  tone_gen #(
    .DIV_W(DIV_W)
  ) u_tone (
    .clk  (CLK),
    .rst_n(RST_N),
    .en   (tone_en),
    .clr  (tone_clr),
    .div  (div_q),
    .wave (wave)
  );

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player: per-cycle comparison of busy/done/note_idx/Music against a
// note-timeline model built from the table, with random extra starts, sel churn and stops.
module tb_music_player;
  import music_pkg::*;

  localparam int TICK     = 4;
  localparam int GAP      = 1;
  localparam int NOTES    = 8;
  localparam int PATTERNS = 4;
  localparam int SEL_W    = 2;
  localparam int IDX_W    = 3;
`ifdef MUSIC_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] idx;
    logic             music;
  } obs_t;

  function automatic table_t tb_table();
    table_t t;
    t = '0;
    t[0][0] = mk_note(5, 3);
    t[0][1] = mk_note(0, 2);
    t[1][0] = mk_note(2, 1);
    t[1][1] = mk_note(3, 2);
    t[1][2] = mk_note(0, 1);
    t[1][3] = mk_note(4, 1);
    t[1][4] = mk_note(1, 2);
    t[1][5] = mk_note(6, 1);
    t[1][6] = mk_note(2, 1);
    t[1][7] = mk_note(3, 2);
    t[3][0] = mk_note(3, 2);
    t[3][1] = mk_note(7, 1);
    t[3][2] = mk_note(0, 1);
    t[3][3] = mk_note(4, 3);
    return t;
  endfunction

  localparam table_t TB_TABLE = tb_table();

  logic             CLK   = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic [SEL_W-1:0] sel   = '0;
  logic             busy, done, Music;
  logic [IDX_W-1:0] note_idx;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  music_player #(
    .CLK_HZ   (100000),
    .DIV_W    (10),
    .DUR_W    (10),
    .NOTES    (NOTES),
    .PATTERNS (PATTERNS),
    .TICK_CYC (TICK),
    .GAP_TICKS(GAP),
    .TABLE    (TB_TABLE)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start   (start),
    .sel     (sel),
    .stop    (stop),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx),
    .Music   (Music)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t mk(input bit b, input bit d, input int i, input bit m);
    obs_t o;
    o.busy  = b;
    o.done  = d;
    o.idx   = IDX_W'(i);
    o.music = m;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t want);
    obs_t got;
    got.busy  = busy;
    got.done  = done;
    got.idx   = note_idx;
    got.music = Music;
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Timeline per note: one LOAD cycle, dur*TICK PLAY cycles where the square wave is
  // high in every odd block of div cycles, then GAP*TICK silent cycles.
  task automatic build_model(input int s, input int limit);
    int n, div, dur;
    bit ended;
    exp_q.delete();
    n = 0;
    ended = 0;
    while (!ended && exp_q.size() < limit) begin
      div = int'(TB_TABLE[s][n].div);
      dur = int'(TB_TABLE[s][n].dur);
      exp_q.push_back(mk(1, 0, n, 0));
      if (dur == 0) begin
        if (REPEAT && n != 0) n = 0;
        else ended = 1;
      end else begin
        for (int c = 0; c < dur * TICK; c++)
          exp_q.push_back(mk(1, 0, n, (div != 0) && (((c / div) % 2) == 1)));
        for (int c = 0; c < GAP * TICK; c++)
          exp_q.push_back(mk(1, 0, n, 0));
        if (n == NOTES - 1) begin
          if (REPEAT) n = 0;
          else ended = 1;
        end else begin
          n++;
        end
      end
    end
    if (ended) exp_q.push_back(mk(0, 1, 0, 0));
  endtask

  task automatic run_play(input string name, input int s, input int stop_at_in,
                          input int stop_note, input bit rand_start, output int busy_cnt);
    int last, stop_at;
    bit stopped;
    build_model(s, 400);
    last     = exp_q.size() - 1;
    stop_at  = stop_at_in;
    busy_cnt = 0;
    stopped  = 0;
    if (stop_note >= 0) begin
      for (int k = 0; k <= last; k++) begin
        if (exp_q[k].busy && exp_q[k].idx == IDX_W'(stop_note)) begin
          stop_at = k + 3;
          break;
        end
      end
    end
    if (exp_q[last].done) begin
      if (stop_at >= last) stop_at = -1;
    end else if (stop_at < 0 || stop_at > last) begin
      stop_at = last;
    end
    @(negedge CLK);
    start = 1'b1;
    sel   = SEL_W'(s);
    @(negedge CLK);
    start = 1'b0;
    sel   = SEL_W'($urandom);
    for (int k = 0; k <= last; k++) begin
      check($sformatf("%s[%0d]", name, k), exp_q[k]);
      if (busy) busy_cnt++;
      if (k == stop_at) begin
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        check({name, "_stopped"}, mk(0, 0, 0, 0));
        stopped = 1;
        break;
      end
      if (rand_start && k < last - 1) begin
        start = 1'($urandom_range(0, 1));
        sel   = SEL_W'($urandom);
      end
      @(negedge CLK);
      start = 1'b0;
    end
    @(negedge CLK);
    check({name, "_idle"}, mk(0, 0, 0, 0));
    $display("play %s sel=%0d model_cycles=%0d busy_cycles=%0d stopped=%0d",
             name, s, last + 1, busy_cnt, stopped);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bt;
    int s, sa;
    RST_N = 1'b0;
    #1 check("reset_async", mk(0, 0, 0, 0));
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("reset_release", mk(0, 0, 0, 0));

    run_play("p0_rest", 0, -1, -1, 1'b0, bt);
`ifndef MUSIC_REPEAT_EN
    checks++;
    assert (bt === 31) else begin
      failures++;
      $error("FAIL p0_busy_total observed=%0d expected=%0d", bt, 31);
    end
`endif
    run_play("p1_full", 1, -1, -1, 1'b1, bt);
    run_play("p2_term", 2, -1, -1, 1'b0, bt);
    run_play("p1_stop2", 1, -1, 2, 1'b0, bt);
    run_play("p3_mix", 3, -1, -1, 1'b1, bt);

    @(negedge CLK);
    start = 1'b1;
    stop  = 1'b1;
    sel   = '0;
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", mk(0, 0, 0, 0));
    @(negedge CLK);
    check("start_stop_idle2", mk(0, 0, 0, 0));
    $display("step start_stop_idle done");

    for (int i = 0; i < 6; i++) begin
      s  = $urandom_range(0, 3);
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1;
      run_play($sformatf("rand%0d", i), s, sa, -1, 1'b1, bt);
    end

    // Pattern 0 is mid-note after six PLAY cycles: div 5 puts Music high.
    @(negedge CLK);
    start = 1'b1;
    sel   = '0;
    @(negedge CLK);
    start = 1'b0;
    repeat (6) @(negedge CLK);
    check("pre_reset_play", mk(1, 0, 0, 1));
    #2 RST_N = 1'b0;
    #1 check("reset_mid_note", mk(0, 0, 0, 0));
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("after_reset_release", mk(0, 0, 0, 0));
    $display("step reset_mid_note done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
